// File: rtl/mu9_rr_arbiter.sv
// rtl/mu9_rr_arbiter.sv - round-robin arbiter driving the shared result-mux select
// Grants one source at a time, with bounded bursts and back-to-back re-grant on release.
module mu9_rr_arbiter #(
  parameter int N_SRC     = 9,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             bus_ready,
  output logic [3:0]       sel,
  output logic             bus_valid,
  output logic [N_SRC-1:0] ack,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  localparam logic [3:0] LP_LAST = 4'(N_SRC - 1);
  localparam logic [3:0] LP_MAXB = 4'(MAX_BURST);

  state_t           r_state, w_state_n;
  logic [3:0]       r_sel, w_sel_n;
  logic             r_bus_valid, w_bus_valid_n;
  logic [3:0]       r_rr_ptr, w_rr_ptr_n;
  logic [3:0]       r_beat_cnt, w_beat_cnt_n;

  logic [N_SRC-1:0] w_sel_oh;
  logic             w_beat;
  logic             w_req_sel;
  logic             w_burst_end;
  logic             w_release;
  logic [3:0]       w_rel_ptr;
  logic [4:0]       w_pick_idle;
  logic [4:0]       w_pick_rel;

  // Returns {found, index}: first requester scanning upward from i_ptr with wrap.
  function automatic logic [4:0] f_pick(input logic [N_SRC-1:0] i_req, input logic [3:0] i_ptr);
    logic [4:0] v_res;
    logic [3:0] v_idx;
    v_res = '0;
    v_idx = i_ptr;
    for (int k = 0; k < N_SRC; k++) begin
      if (!v_res[4] && i_req[v_idx]) v_res = {1'b1, v_idx};
      v_idx = (v_idx == LP_LAST) ? 4'd0 : v_idx + 4'd1;
    end
    return v_res;
  endfunction

  assign w_sel_oh    = N_SRC'(1) << r_sel;
  assign w_beat      = r_bus_valid & bus_ready;
  assign w_req_sel   = |(req & w_sel_oh);
  assign w_burst_end = ((r_beat_cnt + 4'd1) >= LP_MAXB);
  assign w_release   = !w_req_sel || (w_beat && w_burst_end);
  assign w_rel_ptr   = (r_sel == LP_LAST) ? 4'd0 : r_sel + 4'd1;
  // The current owner sits last in the scan from sel+1, so it only re-wins when alone.
  assign w_pick_idle = f_pick(req, r_rr_ptr);
  assign w_pick_rel  = f_pick(req, w_rel_ptr);

  always_comb begin
    w_state_n     = r_state;
    w_sel_n       = r_sel;
    w_bus_valid_n = r_bus_valid;
    w_rr_ptr_n    = r_rr_ptr;
    w_beat_cnt_n  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        w_bus_valid_n = 1'b0;
        if (w_pick_idle[4]) begin
          w_sel_n       = w_pick_idle[3:0];
          w_bus_valid_n = 1'b1;
          w_beat_cnt_n  = 4'd0;
          w_state_n     = S_OWN;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_rr_ptr_n = w_rel_ptr;
          if (w_pick_rel[4]) begin
            w_sel_n       = w_pick_rel[3:0];
            w_beat_cnt_n  = 4'd0;
            w_bus_valid_n = 1'b1;
          end else begin
            w_bus_valid_n = 1'b0;
            w_beat_cnt_n  = 4'd0;
            w_state_n     = S_IDLE;
          end
        end else if (w_beat) begin
          w_beat_cnt_n = r_beat_cnt + 4'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sel       <= 4'd0;
      r_bus_valid <= 1'b0;
      r_rr_ptr    <= 4'd0;
      r_beat_cnt  <= 4'd0;
    end else begin
      r_state     <= w_state_n;
      r_sel       <= w_sel_n;
      r_bus_valid <= w_bus_valid_n;
      r_rr_ptr    <= w_rr_ptr_n;
      r_beat_cnt  <= w_beat_cnt_n;
    end
  end

  assign sel       = r_sel;
  assign bus_valid = r_bus_valid;
  assign ack       = w_sel_oh & {N_SRC{w_beat}};
  assign busy      = (r_state == S_OWN);

endmodule

// File: tb/tb_mu9_rr_arbiter.sv
// tb/tb_mu9_rr_arbiter.sv - directed self-checking bench for mu9_rr_arbiter
module tb_mu9_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [8:0] req;
  logic       bus_ready;
  logic [3:0] sel;
  logic       bus_valid;
  logic [8:0] ack;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  mu9_rr_arbiter #(.N_SRC(9), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bus_ready (bus_ready),
    .sel       (sel),
    .bus_valid (bus_valid),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req = 9'h000;
    bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 9'h000;
    bus_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel, bus_valid, ack, busy} !== {4'd0, 1'b0, 9'h000, 1'b0})
        $display("FAIL reset_c%0d sel=%0d valid=%b ack=%h busy=%b want 0/0/000/0", c, sel, bus_valid, ack, busy);
      else n_pass++;
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    req = 9'h004;
    bus_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel, bus_valid, ack, busy} !== {4'd2, 1'b1, 9'h004, 1'b1})
        $display("FAIL single_c%0d sel=%0d valid=%b ack=%h busy=%b want 2/1/004/1", c, sel, bus_valid, ack, busy);
      else n_pass++;
    end
    req = 9'h000;
    @(negedge clk);
    n_total++;
    if ({bus_valid, ack, busy} !== {1'b0, 9'h000, 1'b0})
      $display("FAIL single_idle valid=%b ack=%h busy=%b want 0/000/0", bus_valid, ack, busy);
    else n_pass++;
    bus_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] e_sel;
    logic [8:0] e_ack;
    apply_reset();
    req = 9'h1FF;
    bus_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      @(negedge clk);
      e_sel = 4'((b / 4) % 9);
      e_ack = 9'h001 << e_sel;
      n_total++;
      if ({sel, bus_valid, ack} !== {e_sel, 1'b1, e_ack})
        $display("FAIL rr_beat%0d sel=%0d valid=%b ack=%h want %0d/1/%h", b, sel, bus_valid, ack, e_sel, e_ack);
      else n_pass++;
      n_total++;
      if (sel > 4'd8)
        $display("FAIL rr_sel_range beat%0d sel=%0d want <=8", b, sel);
      else n_pass++;
    end
    req = 9'h000;
    @(negedge clk);
    n_total++;
    if (bus_valid !== 1'b0)
      $display("FAIL rr_idle valid=%b want 0", bus_valid);
    else n_pass++;
    bus_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req = 9'h020;
    bus_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel, bus_valid, ack} !== {4'd5, 1'b1, 9'h000})
        $display("FAIL bp_hold_c%0d sel=%0d valid=%b ack=%h want 5/1/000", c, sel, bus_valid, ack);
      else n_pass++;
    end
    bus_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      else #1;
      n_total++;
      if ({sel, bus_valid, ack} !== {4'd5, 1'b1, 9'h020})
        $display("FAIL bp_flow_c%0d sel=%0d valid=%b ack=%h want 5/1/020", c, sel, bus_valid, ack);
      else n_pass++;
    end
    req = 9'h000;
    @(negedge clk);
    n_total++;
    if ({bus_valid, ack} !== {1'b0, 9'h000})
      $display("FAIL bp_idle valid=%b ack=%h want 0/000", bus_valid, ack);
    else n_pass++;
    bus_ready = 1'b0;
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    req = 9'h080;
    bus_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({sel, ack} !== {4'd7, 9'h080})
      $display("FAIL wrap_prime sel=%0d ack=%h want 7/080", sel, ack);
    else n_pass++;
    req = 9'h000;
    @(negedge clk);
    req = 9'h101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel, bus_valid, ack} !== {4'd8, 1'b1, 9'h100})
        $display("FAIL wrap_src8_c%0d sel=%0d valid=%b ack=%h want 8/1/100", c, sel, bus_valid, ack);
      else n_pass++;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel, bus_valid, ack} !== {4'd0, 1'b1, 9'h001})
        $display("FAIL wrap_src0_c%0d sel=%0d valid=%b ack=%h want 0/1/001", c, sel, bus_valid, ack);
      else n_pass++;
    end
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({sel, bus_valid, ack, busy} !== {4'd0, 1'b0, 9'h000, 1'b0})
      $display("FAIL wrap_async_rst sel=%0d valid=%b ack=%h busy=%b want 0/0/000/0", sel, bus_valid, ack, busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({sel, bus_valid, ack} !== {4'd0, 1'b1, 9'h001})
      $display("FAIL wrap_restart sel=%0d valid=%b ack=%h want 0/1/001", sel, bus_valid, ack);
    else n_pass++;
    req = 9'h000;
    @(negedge clk);
    bus_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    apply_reset();
    req = 9'h008;
    bus_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if ({sel, bus_valid, ack} !== {4'd3, 1'b1, 9'h000})
      $display("FAIL wd_grant3 sel=%0d valid=%b ack=%h want 3/1/000", sel, bus_valid, ack);
    else n_pass++;
    req = 9'h040;
    @(negedge clk);
    n_total++;
    if ({sel, bus_valid, ack} !== {4'd6, 1'b1, 9'h000})
      $display("FAIL wd_regrant6 sel=%0d valid=%b ack=%h want 6/1/000", sel, bus_valid, ack);
    else n_pass++;
    bus_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({sel, ack} !== {4'd6, 9'h040})
      $display("FAIL wd_ack6 sel=%0d ack=%h want 6/040", sel, ack);
    else n_pass++;
    req = 9'h000;
    @(negedge clk);
    n_total++;
    if (bus_valid !== 1'b0)
      $display("FAIL wd_idle valid=%b want 0", bus_valid);
    else n_pass++;
    bus_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req = 9'h000;
    bus_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_reset();
    test_withdraw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
